alu_rs: RTL
===========

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of entries (power of two, 2..16).
REQ-002 Parameter ROB_WIDTH, default 4, ROB tag width; tag 0 is a valid tag.
REQ-003 Parameter RS_TYPE_WIDTH, default 6, operation type code width, passed through unchanged.
REQ-004 Ports, one per line:
- clk_in  in  1  clock.
- rst_in  in  1  reset; one clock; synchronous, active-high.
- rdy_in  in  1  global enable; low = freeze all state.
- flush  in  1  misprediction flush.
- full  out  1  no free entry (combinational).
- disp_en  in  1  dispatch request.
- disp_rob_id  in  ROB_WIDTH  destination tag.
- disp_type  in  RS_TYPE_WIDTH  operation type.
- disp_imm  in  32  immediate.
- disp_qj_busy / disp_qk_busy  in  1  operand j / k pending.
- disp_qj / disp_qk  in  ROB_WIDTH  producer tag of j / k.
- disp_vj / disp_vk  in  32  operand value when not pending.
- cdb_alu_en, cdb_alu_rob_id, cdb_alu_val  in  1/ROB_WIDTH/32  ALU result broadcast.
- cdb_mem_en, cdb_mem_rob_id, cdb_mem_val  in  1/ROB_WIDTH/32  load result broadcast.
- issue_en  out  1  registered ALU enable.
- issue_rob_id  out  ROB_WIDTH  registered.
- issue_data_j / issue_data_k / issue_imm  out  32  registered.
- issue_type  out  RS_TYPE_WIDTH  registered.

Function
REQ-005 Each entry SHALL hold busy, rob_id, type, imm, qj_busy, qj, vj, qk_busy, qk, vk.
REQ-006 full SHALL be 1 iff every entry is busy in the current state; an issue in the same cycle does not clear full.
REQ-007 disp_en with full=0 and rdy_in=1 SHALL write the lowest-index non-busy entry at the clock edge; disp_en while full=1 SHALL be ignored.
REQ-008 Wake-up: at each enabled edge, every busy entry with qX_busy=1 and qX equal to an active CDB tag SHALL capture that CDB value into vX and clear qX_busy.
REQ-009 Dispatch bypass: a dispatched operand whose disp_qX matches an active CDB tag in the same cycle SHALL be stored as ready with the CDB value.
REQ-010 If both CDBs carry the same tag in one cycle, cdb_alu_val SHALL take priority.
REQ-011 An entry is ready when busy=1, qj_busy=0 and qk_busy=0, evaluated from registered state only; wake-up to issue is at least one cycle.
REQ-012 Each enabled cycle, the lowest-index ready entry SHALL be selected.
REQ-013 On selection, the outputs SHALL be driven at the next edge from the entry's fields, with issue_en=1, and the entry's busy SHALL be cleared at that same edge.
REQ-014 A freed entry SHALL be allocatable in the following cycle.
REQ-015 With no ready entry, issue_en SHALL be 0 at the next edge; other issue outputs are don't-care.
REQ-016 Throughput SHALL be one issue per cycle; dispatch and issue SHALL proceed concurrently.
REQ-017 rdy_in=0 SHALL hold all entries and all outputs; dispatch, wake-up and issue are suppressed.
REQ-018 flush with rdy_in=1 SHALL clear every busy bit and issue_en at the edge, discarding any same-cycle dispatch and CDB capture.

Reset
REQ-019 rst_in=1 SHALL clear all entries (busy=0) and drive issue_en=0, issue_rob_id=0, issue_data_j=0, issue_data_k=0, issue_imm=0, issue_type=0, regardless of rdy_in.
REQ-020 rst_in has priority over flush and dispatch; the block is operational from the first edge with rst_in=0.

Verification
REQ-021 Dispatch rob 3, vj=5, vk=7, both ready, idle RS -> next edge entry 0 busy; following edge issue_en=1, rob_id=3, data_j=5, data_k=7; entry 0 free.
REQ-022 Dispatch rob 2 with qj=6 pending; cdb_alu_en rob 6 val 0x10 two cycles later -> issue_en only the cycle after capture, issue_data_j=0x10.
REQ-023 Dispatch rob 4 with qk=1 while cdb_mem broadcasts rob 1 val 0xAB same cycle -> entry stored ready; issue next cycle with issue_data_k=0xAB.
REQ-024 Fill all 8 entries with pending operands -> full=1; a 9th dispatch ignored; wake entries 5 and 2 together -> entry 2 issues first, then 5.
REQ-025 Flush with 3 busy entries plus a same-cycle dispatch -> all entries free, issue_en=0 next edge, full=0, no later issue.
REQ-026 Hold rdy_in=0 for 3 cycles with a ready entry and an active CDB -> no state change; issue resumes the cycle after rdy_in returns to 1.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops two result buses, and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_SIZE       = 8,
  parameter int ROB_WIDTH     = 4,
  parameter int RS_TYPE_WIDTH = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  output logic                     full,
  input  logic                     disp_en,
  input  logic [ROB_WIDTH-1:0]     disp_rob_id,
  input  logic [RS_TYPE_WIDTH-1:0] disp_type,
  input  logic [31:0]              disp_imm,
  input  logic                     disp_qj_busy,
  input  logic                     disp_qk_busy,
  input  logic [ROB_WIDTH-1:0]     disp_qj,
  input  logic [ROB_WIDTH-1:0]     disp_qk,
  input  logic [31:0]              disp_vj,
  input  logic [31:0]              disp_vk,
  input  logic                     cdb_alu_en,
  input  logic [ROB_WIDTH-1:0]     cdb_alu_rob_id,
  input  logic [31:0]              cdb_alu_val,
  input  logic                     cdb_mem_en,
  input  logic [ROB_WIDTH-1:0]     cdb_mem_rob_id,
  input  logic [31:0]              cdb_mem_val,
  output logic                     issue_en,
  output logic [ROB_WIDTH-1:0]     issue_rob_id,
  output logic [31:0]              issue_data_j,
  output logic [31:0]              issue_data_k,
  output logic [31:0]              issue_imm,
  output logic [RS_TYPE_WIDTH-1:0] issue_type
);

  localparam int IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic                     busy;
    logic [ROB_WIDTH-1:0]     robId;
    logic [RS_TYPE_WIDTH-1:0] opType;
    logic [31:0]              imm;
    logic                     qjBusy;
    logic [ROB_WIDTH-1:0]     qj;
    logic [31:0]              vj;
    logic                     qkBusy;
    logic [ROB_WIDTH-1:0]     qk;
    logic [31:0]              vk;
  } entry_t;

  entry_t                   entries_q [RS_SIZE];
  entry_t                   entries_d [RS_SIZE];
  logic                     issueEn_q, issueEn_d;
  logic [ROB_WIDTH-1:0]     issueRob_q, issueRob_d;
  logic [31:0]              issueJ_q, issueJ_d;
  logic [31:0]              issueK_q, issueK_d;
  logic [31:0]              issueImm_q, issueImm_d;
  logic [RS_TYPE_WIDTH-1:0] issueType_q, issueType_d;

  logic            freeFound, readyFound;
  logic [IdxW-1:0] freeIdx, selIdx;

  // Returns {still pending, value}; the ALU bus wins when both carry the same tag.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_WIDTH-1:0] tag,
                                        input logic [31:0] val);
    logic [32:0] r;
    r = {pend, val};
    if (pend && cdb_alu_en && tag == cdb_alu_rob_id)      r = {1'b0, cdb_alu_val};
    else if (pend && cdb_mem_en && tag == cdb_mem_rob_id) r = {1'b0, cdb_mem_val};
    return r;
  endfunction

  always_comb begin
    freeFound  = 1'b0;
    freeIdx    = '0;
    readyFound = 1'b0;
    selIdx     = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!freeFound && !entries_q[i].busy) begin
        freeFound = 1'b1;
        freeIdx   = IdxW'(i);
      end
      if (!readyFound && entries_q[i].busy && !entries_q[i].qjBusy && !entries_q[i].qkBusy) begin
        readyFound = 1'b1;
        selIdx     = IdxW'(i);
      end
    end
    full = !freeFound;

    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy) begin
        {entries_d[i].qjBusy, entries_d[i].vj} = snoop(entries_q[i].qjBusy, entries_q[i].qj, entries_q[i].vj);
        {entries_d[i].qkBusy, entries_d[i].vk} = snoop(entries_q[i].qkBusy, entries_q[i].qk, entries_q[i].vk);
      end
    end

    issueEn_d   = readyFound;
    issueRob_d  = issueRob_q;
    issueJ_d    = issueJ_q;
    issueK_d    = issueK_q;
    issueImm_d  = issueImm_q;
    issueType_d = issueType_q;
    if (readyFound) begin
      issueRob_d  = entries_q[selIdx].robId;
      issueJ_d    = entries_q[selIdx].vj;
      issueK_d    = entries_q[selIdx].vk;
      issueImm_d  = entries_q[selIdx].imm;
      issueType_d = entries_q[selIdx].opType;
      entries_d[selIdx].busy = 1'b0;
    end

    // The free slot is never the issuing slot, so dispatch cannot collide with issue.
    if (disp_en && freeFound) begin
      entries_d[freeIdx].busy   = 1'b1;
      entries_d[freeIdx].robId  = disp_rob_id;
      entries_d[freeIdx].opType = disp_type;
      entries_d[freeIdx].imm    = disp_imm;
      entries_d[freeIdx].qj     = disp_qj;
      entries_d[freeIdx].qk     = disp_qk;
      {entries_d[freeIdx].qjBusy, entries_d[freeIdx].vj} = snoop(disp_qj_busy, disp_qj, disp_vj);
      {entries_d[freeIdx].qkBusy, entries_d[freeIdx].vk} = snoop(disp_qk_busy, disp_qk, disp_vk);
    end

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) entries_d[i].busy = 1'b0;
      issueEn_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
      issueEn_q   <= 1'b0;
      issueRob_q  <= '0;
      issueJ_q    <= '0;
      issueK_q    <= '0;
      issueImm_q  <= '0;
      issueType_q <= '0;
    end else if (rdy_in) begin
      entries_q   <= entries_d;
      issueEn_q   <= issueEn_d;
      issueRob_q  <= issueRob_d;
      issueJ_q    <= issueJ_d;
      issueK_q    <= issueK_d;
      issueImm_q  <= issueImm_d;
      issueType_q <= issueType_d;
    end
  end

  assign issue_en     = issueEn_q;
  assign issue_rob_id = issueRob_q;
  assign issue_data_j = issueJ_q;
  assign issue_data_k = issueK_q;
  assign issue_imm    = issueImm_q;
  assign issue_type   = issueType_q;

endmodule
